// File: rtl/fft_tf_pkg.sv
// fft_tf_pkg
// Shared definitions for the twiddle-factor scheduling logic of the FFT stages:
//   - LOG2_N_DEF      : default log2 of the FFT length
//   - tf_addr_width() : twiddle ROM address width for a given log2 length (ROM holds N/2 factors)
//   - ST_*            : state encoding of the twiddle address scheduler
//   - stage_legal()   : legality check for a requested stage number
package fft_tf_pkg;

  localparam int LOG2_N_DEF = 13;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic int tf_addr_width(input int log2n);
    return log2n - 1;
  endfunction

  // A stage is legal when it lies in 1..log2n.
  function automatic logic stage_legal(input int unsigned stage, input int unsigned log2n);
    return (stage >= 32'd1) && (stage <= log2n);
  endfunction

endpackage

// File: rtl/tf_valid_pipe.sv
// tf_valid_pipe
// DEPTH-deep single-bit shift register used to align a valid strobe with a
// fixed-latency memory read. A synchronous flush clears every pending valid.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   flush in  synchronous clear of all stages
//   din   in  valid entering the pipe
//   dout  out din delayed by DEPTH cycles
module tf_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  // Shift register; bit 0 is the youngest entry, the cast drops the oldest bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= {DEPTH{1'b0}};
    end else if (flush) begin
      sr <= {DEPTH{1'b0}};
    end else begin
      sr <= DEPTH'({sr, din});
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/tf_addr_scheduler.sv
// tf_addr_scheduler
// Sequences the twiddle-factor ROM for one radix-2 DIT FFT stage per frame.
// A start in IDLE latches the stage; every adv in RUN issues one ROM read at
// address (cnt mod 2^(stage-1)) << (LOG2_N-stage). After N/2 reads the block
// drains the ROM latency, pulses frame_done and returns to IDLE.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       frame request (IDLE only), stage_sel latched with it
//   adv         butterfly advance strobe, one read per cycle in RUN
//   abort       cancel the current frame (RUN/DRAIN)
//   tf_addr     registered ROM address
//   tf_en       registered ROM enable, aligned with tf_addr
//   tf_valid    tf_en delayed by ROM_LAT, marks ROM data valid
//   busy        high in RUN and DRAIN
//   frame_done  one-cycle pulse at the end of DRAIN
//   stage_err   one-cycle pulse for a start with an illegal stage
module tf_addr_scheduler
  import fft_tf_pkg::*;
#(
  parameter int LOG2_N    = LOG2_N_DEF,
  parameter int STAGE_W   = 4,
  parameter int TF_ADDR_W = tf_addr_width(LOG2_N),
  parameter int ROM_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [STAGE_W-1:0]   stage_sel,
  input  logic                 adv,
  input  logic                 abort,
  output logic [TF_ADDR_W-1:0] tf_addr,
  output logic                 tf_en,
  output logic                 tf_valid,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 stage_err
);

  localparam int CNT_W = LOG2_N - 1;

  logic [1:0]           state;
  logic [1:0]           state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nx;
  logic [STAGE_W-1:0]   stage_q;
  logic [STAGE_W-1:0]   stage_nx;
  logic [2:0]           drain_cnt;
  logic [2:0]           drain_nx;
  logic [TF_ADDR_W-1:0] tf_addr_nx;
  logic                 tf_en_nx;
  logic                 frame_done_nx;
  logic                 stage_err_nx;
  logic                 flush;
  logic                 start_legal;
  logic                 last_read;
  logic [CNT_W-1:0]     addr_mask;
  logic [TF_ADDR_W-1:0] addr_calc;

  assign start_legal = stage_legal(32'(stage_sel), 32'(LOG2_N));
  assign last_read   = (cnt == {CNT_W{1'b1}});

  // Twiddle address: keep the low (stage-1) bits of cnt and left-align them.
  always_comb begin
    addr_mask = CNT_W'((32'd1 << (32'(stage_q) - 32'd1)) - 32'd1);
    addr_calc = TF_ADDR_W'((cnt & addr_mask) << (32'(LOG2_N) - 32'(stage_q)));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= {CNT_W{1'b0}};
      stage_q    <= STAGE_W'(1);
      drain_cnt  <= 3'd0;
      tf_addr    <= {TF_ADDR_W{1'b0}};
      tf_en      <= 1'b0;
      frame_done <= 1'b0;
      stage_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      stage_q    <= stage_nx;
      drain_cnt  <= drain_nx;
      tf_addr    <= tf_addr_nx;
      tf_en      <= tf_en_nx;
      frame_done <= frame_done_nx;
      stage_err  <= stage_err_nx;
    end
  end

  // Next-state logic; abort has priority in every state.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start && !abort && start_legal) begin
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (adv && last_read) begin
          state_nx = ST_DRAIN;
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // frame_done is already high in the final DRAIN cycle, so leave then.
        if (abort || frame_done) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_DRAIN;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    cnt_nx        = cnt;
    stage_nx      = stage_q;
    drain_nx      = drain_cnt;
    tf_addr_nx    = tf_addr;
    tf_en_nx      = 1'b0;
    frame_done_nx = 1'b0;
    stage_err_nx  = 1'b0;
    flush         = 1'b0;
    case (state)
      ST_IDLE: begin
        drain_nx = 3'd0;
        if (start && !abort) begin
          if (start_legal) begin
            stage_nx = stage_sel;
            cnt_nx   = {CNT_W{1'b0}};
          end else begin
            stage_err_nx = 1'b1;
          end
        end else begin
          stage_nx = stage_q;
        end
      end
      ST_RUN: begin
        drain_nx = 3'd0;
        if (abort) begin
          cnt_nx = {CNT_W{1'b0}};
          flush  = 1'b1;
        end else if (adv) begin
          tf_en_nx   = 1'b1;
          tf_addr_nx = addr_calc;
          cnt_nx     = cnt + CNT_W'(1);
        end else begin
          tf_en_nx = 1'b0;
        end
      end
      ST_DRAIN: begin
        // ROM_LAT cycles let the last valid leave the pipe, then one pulse.
        if (abort) begin
          cnt_nx   = {CNT_W{1'b0}};
          drain_nx = 3'd0;
          flush    = 1'b1;
        end else if (!frame_done) begin
          drain_nx = drain_cnt + 3'd1;
          if (drain_cnt == 3'(ROM_LAT)) begin
            frame_done_nx = 1'b1;
          end else begin
            frame_done_nx = 1'b0;
          end
        end else begin
          drain_nx = 3'd0;
        end
      end
      default: begin
        cnt_nx = {CNT_W{1'b0}};
        flush  = 1'b1;
      end
    endcase
  end

  assign busy = (state != ST_IDLE);

  tf_valid_pipe #(
    .DEPTH(ROM_LAT)
  ) u_valid_pipe (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .din  (tf_en),
    .dout (tf_valid)
  );

endmodule

// File: tb/tb_tf_addr_scheduler.sv
module tb_tf_addr_scheduler;

  localparam int LOG2_N    = 13;
  localparam int STAGE_W   = 4;
  localparam int TF_ADDR_W = 12;
  localparam int ROM_LAT   = 3;
  localparam int HALF      = 4096;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [STAGE_W-1:0]   stage_sel;
  logic                 adv;
  logic                 abort;
  logic [TF_ADDR_W-1:0] tf_addr;
  logic                 tf_en;
  logic                 tf_valid;
  logic                 busy;
  logic                 frame_done;
  logic                 stage_err;

  int n_tests = 0;
  int n_fail  = 0;
  int addrs[$];

  always #5 clk = ~clk;

  tf_addr_scheduler #(
    .LOG2_N(LOG2_N), .STAGE_W(STAGE_W), .TF_ADDR_W(TF_ADDR_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stage_sel(stage_sel), .adv(adv), .abort(abort),
    .tf_addr(tf_addr), .tf_en(tf_en), .tf_valid(tf_valid), .busy(busy),
    .frame_done(frame_done), .stage_err(stage_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Frame-level view: a frame is active, has done m_reads reads, and after
  // N/2 reads waits ROM_LAT+1 cycles before announcing completion.
  bit       m_on = 1'b0;
  bit       m_active, m_drain;
  int       m_reads, m_dleft, m_stage;
  bit       vh[ROM_LAT];
  int       e_addr;
  bit       e_en, e_valid, e_busy, e_done, e_err;

  always @(posedge clk) begin : model
    bit act, drn, en_n, err_n, done_n, flush_n;
    int rd, dl, stg, addr_n;
    if (rst) begin
      m_on <= 1'b1; m_active <= 1'b0; m_drain <= 1'b0; m_reads <= 0; m_dleft <= 0;
      m_stage <= 1; e_addr <= 0; e_en <= 1'b0; e_valid <= 1'b0; e_busy <= 1'b0;
      e_done <= 1'b0; e_err <= 1'b0;
      for (int i = 0; i < ROM_LAT; i++) vh[i] <= 1'b0;
    end else begin
      act = m_active; drn = m_drain; rd = m_reads; dl = m_dleft; stg = m_stage;
      en_n = 1'b0; err_n = 1'b0; done_n = 1'b0; flush_n = 1'b0; addr_n = e_addr;
      if (!act) begin
        if (start && !abort) begin
          if (int'(stage_sel) >= 1 && int'(stage_sel) <= LOG2_N) begin
            act = 1'b1; drn = 1'b0; rd = 0; stg = int'(stage_sel);
          end else begin
            err_n = 1'b1;
          end
        end
      end else if (abort) begin
        act = 1'b0; flush_n = 1'b1;
      end else if (!drn) begin
        if (adv) begin
          en_n   = 1'b1;
          addr_n = (rd % (1 << (stg - 1))) * (1 << (LOG2_N - stg));
          rd++;
          if (rd == HALF) begin drn = 1'b1; dl = ROM_LAT + 1; end
        end
      end else if (e_done) begin
        act = 1'b0;
      end else begin
        dl--;
        if (dl == 0) done_n = 1'b1;
      end
      m_active <= act; m_drain <= drn; m_reads <= rd; m_dleft <= dl; m_stage <= stg;
      e_addr <= addr_n; e_en <= en_n; e_err <= err_n; e_done <= done_n; e_busy <= act;
      e_valid <= flush_n ? 1'b0 : vh[0];
      for (int i = 0; i < ROM_LAT - 1; i++) vh[i] <= flush_n ? 1'b0 : vh[i+1];
      vh[ROM_LAT-1] <= en_n;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_on) begin
      chk("tf_addr",    int'(tf_addr),    e_addr);
      chk("tf_en",      int'(tf_en),      int'(e_en));
      chk("tf_valid",   int'(tf_valid),   int'(e_valid));
      chk("busy",       int'(busy),       int'(e_busy));
      chk("frame_done", int'(frame_done), int'(e_done));
      chk("stage_err",  int'(stage_err),  int'(e_err));
    end
  end

  // ---------------- directed / random stimulus ----------------
  // mode 0: adv held high, 1: adv toggling starting with 1, 2: random adv.
  task automatic run_frame(input int stage, input int mode, output int reads, output int done_cyc);
    bit seen;
    addrs.delete(); reads = 0; done_cyc = -1; seen = 1'b0;
    start = 1'b1; stage_sel = STAGE_W'(stage);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    for (int k = 0; k < 20000 && !seen; k++) begin
      case (mode)
        0:       adv = 1'b1;
        1:       adv = (k % 2 == 0);
        default: adv = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (tf_en) begin addrs.push_back(int'(tf_addr)); reads++; end
      if (frame_done) begin seen = 1'b1; done_cyc = k + 1; end
    end
    if (!seen) chk("frame_done_timeout", 0, 1);
    // a start coinciding with frame_done must be dropped
    adv = 1'b0; start = 1'b1; stage_sel = 4'd5;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", int'(busy), 0);
  endtask

  initial begin
    int reads, done_cyc, bad, cnt;
    int t4[9] = '{0, 512, 1024, 1536, 2048, 2560, 3072, 3584, 0};
    int t3[8] = '{0, 1024, 2048, 3072, 0, 1024, 2048, 3072};
    rst = 1'b1; start = 1'b0; stage_sel = 4'd0; adv = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_addr", int'(tf_addr), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(tf_valid), 0);
    rst = 1'b0;
    @(negedge clk);

    // stage 4, adv held high
    run_frame(4, 0, reads, done_cyc);
    chk("s4_reads", reads, HALF);
    chk("s4_done_cycle", done_cyc, HALF + ROM_LAT + 1);
    for (int i = 0; i < 9 && i < addrs.size(); i++) chk("s4_addr", addrs[i], t4[i]);
    if (addrs.size() == HALF) chk("s4_last_addr", addrs[HALF-1], 3584);

    // stage 1, random adv: all addresses zero
    run_frame(1, 2, reads, done_cyc);
    chk("s1_reads", reads, HALF);
    bad = 0;
    foreach (addrs[i]) if (addrs[i] != 0) bad++;
    chk("s1_nonzero_addrs", bad, 0);

    // stage 13: address equals read index
    run_frame(13, 0, reads, done_cyc);
    chk("s13_reads", reads, HALF);
    bad = 0;
    foreach (addrs[i]) if (addrs[i] != i) bad++;
    chk("s13_seq_errors", bad, 0);

    // stage 3, adv toggling 1,0,1,0
    run_frame(3, 1, reads, done_cyc);
    chk("s3_reads", reads, HALF);
    chk("s3_done_cycle", done_cyc, 2 * HALF - 2 + 1 + ROM_LAT + 1);
    for (int i = 0; i < 8 && i < addrs.size(); i++) chk("s3_addr", addrs[i], t3[i]);

    // illegal stages
    adv = 1'b1;
    for (int s = 0; s < 3; s++) begin
      start = 1'b1; stage_sel = (s == 0) ? 4'd0 : ((s == 1) ? 4'd14 : 4'd15);
      @(negedge clk);
      start = 1'b0;
      chk("illegal_stage_err", int'(stage_err), 1);
      chk("illegal_busy", int'(busy), 0);
      @(negedge clk);
      chk("illegal_err_pulse", int'(stage_err), 0);
      chk("illegal_no_en", int'(tf_en), 0);
    end
    // abort wins over start in IDLE
    start = 1'b1; abort = 1'b1; stage_sel = 4'd4;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", int'(busy), 0);
    adv = 1'b0;
    @(negedge clk);

    // abort after 100 reads
    start = 1'b1; stage_sel = 4'd6;
    @(negedge clk);
    start = 1'b0; adv = 1'b1; cnt = 0;
    for (int k = 0; k < 300 && cnt < 100; k++) begin
      @(negedge clk);
      if (tf_en) cnt++;
    end
    chk("abort_reads", cnt, 100);
    chk("pre_abort_valid", int'(tf_valid), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; adv = 1'b0;
    chk("abort_en", int'(tf_en), 0);
    chk("abort_valid", int'(tf_valid), 0);
    chk("abort_busy", int'(busy), 0);
    bad = 0;
    repeat (8) begin @(negedge clk); if (frame_done || tf_valid) bad++; end
    chk("abort_no_done", bad, 0);
    run_frame(2, 0, reads, done_cyc);
    chk("s2_reads", reads, HALF);
    if (addrs.size() >= 3) begin
      chk("s2_addr0", addrs[0], 0);
      chk("s2_addr1", addrs[1], 2048);
      chk("s2_addr2", addrs[2], 0);
    end

    // reset mid-RUN
    start = 1'b1; stage_sel = 4'd5;
    @(negedge clk);
    start = 1'b0; adv = 1'b1;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_addr", int'(tf_addr), 0);
      chk("rst_en", int'(tf_en), 0);
      chk("rst_valid", int'(tf_valid), 0);
      chk("rst_busy", int'(busy), 0);
    end
    rst = 1'b0; adv = 1'b0;
    @(negedge clk);
    run_frame(4, 0, reads, done_cyc);
    chk("post_rst_reads", reads, HALF);
    chk("post_rst_done_cycle", done_cyc, HALF + ROM_LAT + 1);
    if (addrs.size() >= 2) begin
      chk("post_rst_addr0", addrs[0], 0);
      chk("post_rst_addr1", addrs[1], 512);
    end

    // random-stage frame with random adv
    run_frame($urandom_range(2, 12), 2, reads, done_cyc);
    chk("rand_reads", reads, HALF);

    // free random traffic, model checks every cycle
    for (int k = 0; k < 3000; k++) begin
      start     = ($urandom_range(0, 9) == 0);
      stage_sel = STAGE_W'($urandom_range(0, 15));
      adv       = 1'($urandom_range(0, 1));
      abort     = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    start = 1'b0; adv = 1'b0; abort = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
